// File: rtl/countdown_timer.sv
// Countdown timer for the DE board: BCD preset from SW, 0.1 s ticks on HEX2..HEX0, alarm on LEDR0.
// Define ALARM_BLINK_EN to blink the 000 display while the alarm is active.
module countdown_timer #(
    parameter int unsigned MIN_COUNT_IN_MS = 100,
    parameter int unsigned FREQ_MHZ        = 50
) (
    input  logic       clk,
    input  logic       KEY0,
    input  logic       KEY1,
    input  logic       KEY2,
    input  logic [7:0] SW,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic       LEDR0
);

    localparam int unsigned Div    = FREQ_MHZ * 1000 * MIN_COUNT_IN_MS;
    localparam int unsigned PscW   = (Div > 1) ? $clog2(Div) : 1;
    localparam logic [PscW-1:0] PscMax = PscW'(Div - 1);

    localparam logic [6:0] SegBlank = 7'h7F;
    localparam logic [6:0] SegZero  = 7'h40;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StPause,
        StDone
    } state_e;

    // ------------------------------------------------------------------
    // Button synchronizers and press detectors
    // ------------------------------------------------------------------
    logic [1:0] key1_sync_q;
    logic [1:0] key2_sync_q;
    logic       key1_prev_q;
    logic       key2_prev_q;
    logic [1:0] settle_q;
    logic       start_p_q;
    logic       load_p_q;
    logic       armed;

    // Detection stays disarmed until the synchronizers hold real samples, so a
    // key held through reset release is not mistaken for a fresh press.
    assign armed = (settle_q == 2'd3);

    always_ff @(posedge clk or negedge KEY0) begin
        if (!KEY0) begin
            key1_sync_q <= 2'b11;
            key2_sync_q <= 2'b11;
            key1_prev_q <= 1'b1;
            key2_prev_q <= 1'b1;
            settle_q    <= 2'd0;
            start_p_q   <= 1'b0;
            load_p_q    <= 1'b0;
        end else begin
            key1_sync_q <= {key1_sync_q[0], KEY1};
            key2_sync_q <= {key2_sync_q[0], KEY2};
            key1_prev_q <= key1_sync_q[1];
            key2_prev_q <= key2_sync_q[1];
            if (!armed) begin
                settle_q <= settle_q + 2'd1;
            end
            start_p_q <= armed & key1_prev_q & ~key1_sync_q[1];
            load_p_q  <= armed & key2_prev_q & ~key2_sync_q[1];
        end
    end

    // ------------------------------------------------------------------
    // Count datapath helpers
    // ------------------------------------------------------------------
    state_e          state_q;
    logic [3:0]      tens_q;
    logic [3:0]      units_q;
    logic [3:0]      tenths_q;
    logic [PscW-1:0] psc_q;

    logic       psc_run;
    logic       tick;
    logic       count_zero;
    logic       dec_zero;
    logic [3:0] dec_tens;
    logic [3:0] dec_units;
    logic [3:0] dec_tenths;
    logic [3:0] ld_tens;
    logic [3:0] ld_units;

`ifdef ALARM_BLINK_EN
    logic [2:0] blink_cnt_q;
    logic       blink_phase_q;

    assign psc_run = (state_q == StRun) || (state_q == StDone);
`else
    assign psc_run = (state_q == StRun);
`endif

    assign tick       = psc_run && (psc_q == PscMax);
    assign count_zero = ({tens_q, units_q, tenths_q} == 12'd0);
    assign dec_zero   = ({dec_tens, dec_units, dec_tenths} == 12'd0);
    assign ld_tens    = (SW[7:4] > 4'd9) ? 4'd9 : SW[7:4];
    assign ld_units   = (SW[3:0] > 4'd9) ? 4'd9 : SW[3:0];

    always_comb begin
        dec_tens   = tens_q;
        dec_units  = units_q;
        dec_tenths = tenths_q - 4'd1;
        if (count_zero) begin
            dec_tenths = 4'd0;
        end else if (tenths_q == 4'd0) begin
            dec_tenths = 4'd9;
            dec_units  = units_q - 4'd1;
            if (units_q == 4'd0) begin
                dec_units = 4'd9;
                dec_tens  = tens_q - 4'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Control FSM, count and prescaler
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge KEY0) begin
        if (!KEY0) begin
            state_q  <= StIdle;
            tens_q   <= 4'd0;
            units_q  <= 4'd0;
            tenths_q <= 4'd0;
            psc_q    <= '0;
        end else begin
            if (psc_run) begin
                psc_q <= tick ? '0 : psc_q + 1'b1;
            end

            if (load_p_q) begin
                state_q  <= StIdle;
                tens_q   <= ld_tens;
                units_q  <= ld_units;
                tenths_q <= 4'd0;
                psc_q    <= '0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (start_p_q && !count_zero) begin
                            state_q <= StRun;
                            psc_q   <= '0;
                        end
                    end
                    StRun: begin
                        // A tick coinciding with start still decrements first.
                        if (tick) begin
                            tens_q   <= dec_tens;
                            units_q  <= dec_units;
                            tenths_q <= dec_tenths;
                            if (dec_zero) begin
                                state_q <= StDone;
                            end else if (start_p_q) begin
                                state_q <= StPause;
                            end
                        end else if (start_p_q) begin
                            state_q <= StPause;
                        end
                    end
                    StPause: begin
                        if (start_p_q) begin
                            state_q <= StRun;
                        end
                    end
                    StDone: begin
                        if (start_p_q) begin
                            state_q  <= StIdle;
                            tens_q   <= 4'd0;
                            units_q  <= 4'd0;
                            tenths_q <= 4'd0;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

`ifdef ALARM_BLINK_EN
    // Phase flips every fifth tick spent in DONE; starts on the visible phase.
    always_ff @(posedge clk or negedge KEY0) begin
        if (!KEY0) begin
            blink_cnt_q   <= 3'd0;
            blink_phase_q <= 1'b0;
        end else if (state_q != StDone) begin
            blink_cnt_q   <= 3'd0;
            blink_phase_q <= 1'b0;
        end else if (tick) begin
            if (blink_cnt_q == 3'd4) begin
                blink_cnt_q   <= 3'd0;
                blink_phase_q <= ~blink_phase_q;
            end else begin
                blink_cnt_q <= blink_cnt_q + 3'd1;
            end
        end
    end
`endif

    // ------------------------------------------------------------------
    // Registered display and alarm outputs
    // ------------------------------------------------------------------
    function automatic logic [6:0] seg7(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = SegBlank;
        endcase
        return seg;
    endfunction

    logic       blank;
    logic [6:0] hex0_q;
    logic [6:0] hex1_q;
    logic [6:0] hex2_q;
    logic       ledr0_q;

    always_comb begin
        blank = 1'b0;
`ifdef ALARM_BLINK_EN
        blank = (state_q == StDone) && blink_phase_q;
`endif
    end

    always_ff @(posedge clk or negedge KEY0) begin
        if (!KEY0) begin
            hex0_q  <= SegZero;
            hex1_q  <= SegZero;
            hex2_q  <= SegZero;
            ledr0_q <= 1'b0;
        end else begin
            hex0_q  <= blank ? SegBlank : seg7(tenths_q);
            hex1_q  <= blank ? SegBlank : seg7(units_q);
            hex2_q  <= blank ? SegBlank : seg7(tens_q);
            ledr0_q <= (state_q == StDone);
        end
    end

    assign HEX0  = hex0_q;
    assign HEX1  = hex1_q;
    assign HEX2  = hex2_q;
    assign LEDR0 = ledr0_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer (DIV = 1000) against an integer-tenths reference model.
module tb_countdown_timer;

    localparam int Div = 1000;

    logic       clk = 1'b0;
    logic       KEY0;
    logic       KEY1;
    logic       KEY2;
    logic [7:0] SW;
    logic [6:0] HEX0;
    logic [6:0] HEX1;
    logic [6:0] HEX2;
    logic       LEDR0;

    always #5 clk = ~clk;

    countdown_timer #(
        .MIN_COUNT_IN_MS(1),
        .FREQ_MHZ       (1)
    ) dut (
        .clk  (clk),
        .KEY0 (KEY0),
        .KEY1 (KEY1),
        .KEY2 (KEY2),
        .SW   (SW),
        .HEX0 (HEX0),
        .HEX1 (HEX1),
        .HEX2 (HEX2),
        .LEDR0(LEDR0)
    );

    int errors = 0;
    int checks = 0;

    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

`ifdef ALARM_BLINK_EN
    localparam bit Blink = 1'b1;
`else
    localparam bit Blink = 1'b0;
`endif

    // Reference model: remaining time as an integer number of tenths.
    int m_cnt;       // remaining tenths
    int m_st;        // 0 idle, 1 run, 2 pause, 3 done
    int m_psc;       // RUN cycles since last tick
    int m_blink;     // ticks spent in DONE
    int m_disp;      // value currently on the display registers
    bit m_disp_done;
    bit m_disp_blank;
    bit ev_start;
    bit ev_load;

    function automatic int load_val(input logic [7:0] s);
        int hi;
        int lo;
        hi = int'(s[7:4]);
        lo = int'(s[3:0]);
        if (hi > 9) hi = 9;
        if (lo > 9) lo = 9;
        return hi * 100 + lo * 10;
    endfunction

    function automatic logic [21:0] exp_out();
        logic [6:0] h2;
        logic [6:0] h1;
        logic [6:0] h0;
        if (m_disp_blank) begin
            h2 = 7'h7F;
            h1 = 7'h7F;
            h0 = 7'h7F;
        end else begin
            h2 = seg_tab[m_disp / 100];
            h1 = seg_tab[(m_disp / 10) % 10];
            h0 = seg_tab[m_disp % 10];
        end
        return {h2, h1, h0, m_disp_done};
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_st = 0; m_psc = 0; m_blink = 0;
        m_disp = 0; m_disp_done = 0; m_disp_blank = 0;
    endtask

    task automatic model_edge();
        bit wrap;
        m_disp       = m_cnt;
        m_disp_done  = (m_st == 3);
        m_disp_blank = Blink && (m_st == 3) && (((m_blink / 5) % 2) == 1);
        wrap = 0;
        if (m_st == 1 || (Blink && m_st == 3)) begin
            m_psc++;
            if (m_psc == Div) begin
                m_psc = 0;
                wrap  = 1;
            end
        end
        if (m_st == 3 && wrap) m_blink++;
        if (ev_load) begin
            m_cnt = load_val(SW); m_st = 0; m_psc = 0;
        end else begin
            case (m_st)
                0: if (ev_start && m_cnt != 0) begin m_st = 1; m_psc = 0; end
                1: begin
                    if (wrap) begin
                        m_cnt--;
                        if (m_cnt == 0) begin m_st = 3; m_blink = 0; end
                        else if (ev_start) m_st = 2;
                    end else if (ev_start) begin
                        m_st = 2;
                    end
                end
                2: if (ev_start) m_st = 1;
                3: if (ev_start) begin m_st = 0; m_cnt = 0; end
                default: m_st = 0;
            endcase
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // Three idle cycles, then a press whose pulse is consumed on the 4th edge.
    task automatic press(input bit s, input bit l);
        repeat (3) cycle();
        if (s) KEY1 = 1'b0;
        if (l) KEY2 = 1'b0;
        cycle(); cycle(); cycle();
        ev_start = s; ev_load = l;
        cycle();
        ev_start = 0; ev_load = 0;
        cycle();
        KEY1 = 1'b1;
        KEY2 = 1'b1;
    endtask

    task automatic test_reset();
        logic [21:0] got;
        KEY0 = 1'b0; KEY1 = 1'b1; KEY2 = 1'b1; SW = 8'h00;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        got = {HEX2, HEX1, HEX0, LEDR0};
        checks++;
        if (got !== exp_out()) begin
            errors++; $display("FAIL reset_hold: got %h want %h", got, exp_out());
        end
        KEY0 = 1'b1;
        repeat (5) cycle();
        got = {HEX2, HEX1, HEX0, LEDR0};
        checks++;
        if (got !== exp_out()) begin
            errors++; $display("FAIL reset_release: got %h want %h", got, exp_out());
        end
        // Load key held through reset release must not load anything.
        SW = 8'h55; KEY2 = 1'b0; KEY0 = 1'b0; model_reset();
        @(posedge clk); #1;
        KEY0 = 1'b1;
        repeat (10) cycle();
        KEY2 = 1'b1;
        repeat (6) cycle();
        got = {HEX2, HEX1, HEX0, LEDR0};
        checks++;
        if (got !== {{3{7'b1000000}}, 1'b0}) begin
            errors++; $display("FAIL held_through_reset: got %h want %h", got, {{3{7'b1000000}}, 1'b0});
        end
    endtask

    task automatic test_load();
        logic [21:0] got;
        SW = 8'h12; KEY2 = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            ev_load = (i == 4);
            cycle();
            got = {HEX2, HEX1, HEX0, LEDR0};
            checks++;
            if (got !== exp_out()) begin
                errors++; $display("FAIL load_latency edge %0d: got %h want %h", i, got, exp_out());
            end
        end
        ev_load = 0; KEY2 = 1'b1;
        checks++;
        if ({HEX2, HEX1, HEX0} !== {7'b1111001, 7'b0100100, 7'b1000000}) begin
            errors++; $display("FAIL load_12: got %h", {HEX2, HEX1, HEX0});
        end
        SW = 8'hFA;
        press(0, 1);
        checks++;
        if ({HEX2, HEX1, HEX0} !== {7'b0010000, 7'b0010000, 7'b1000000}) begin
            errors++; $display("FAIL load_sat: got %h", {HEX2, HEX1, HEX0});
        end
        for (int i = 0; i < 4; i++) begin
            SW = 8'($urandom);
            press(0, 1);
            got = {HEX2, HEX1, HEX0, LEDR0};
            checks++;
            if (got !== exp_out()) begin
                errors++; $display("FAIL load_rand SW=%h: got %h want %h", SW, got, exp_out());
            end
        end
    endtask

    task automatic test_countdown_done();
        logic [21:0] got;
        SW = 8'h01;
        press(0, 1);
        press(1, 0);
        for (int i = 0; i < 10020; i++) begin
            cycle();
            got = {HEX2, HEX1, HEX0, LEDR0};
            checks++;
            if (got !== exp_out()) begin
                errors++; $display("FAIL countdown @%0d: got %h want %h", i, got, exp_out());
            end
        end
        checks++;
        if ({HEX2, HEX1, HEX0, LEDR0} !== {{3{7'b1000000}}, 1'b1}) begin
            errors++; $display("FAIL done_alarm: got %h", {HEX2, HEX1, HEX0, LEDR0});
        end
        press(1, 0);
        got = {HEX2, HEX1, HEX0, LEDR0};
        checks++;
        if (got !== {{3{7'b1000000}}, 1'b0}) begin
            errors++; $display("FAIL done_ack: got %h want %h", got, {{3{7'b1000000}}, 1'b0});
        end
        // Start with count 000 in IDLE must be ignored.
        press(1, 0);
        for (int i = 0; i < 1500; i++) begin
            cycle();
            got = {HEX2, HEX1, HEX0, LEDR0};
            checks++;
            if (got !== exp_out()) begin
                errors++; $display("FAIL start_at_zero @%0d: got %h want %h", i, got, exp_out());
            end
        end
    endtask

    task automatic test_one_tick();
        logic [21:0] got;
        SW = 8'h10;
        press(0, 1);
        press(1, 0);
        for (int i = 0; i < 1005; i++) begin
            cycle();
            got = {HEX2, HEX1, HEX0, LEDR0};
            checks++;
            if (got !== exp_out()) begin
                errors++; $display("FAIL one_tick @%0d: got %h want %h", i, got, exp_out());
            end
        end
        checks++;
        if ({HEX2, HEX1, HEX0} !== {7'b1000000, 7'b0010000, 7'b0010000}) begin
            errors++; $display("FAIL show_09_9: got %h", {HEX2, HEX1, HEX0});
        end
        press(0, 1);
    endtask

    task automatic test_pause_resume();
        logic [21:0] got;
        SW = 8'h12;
        press(0, 1);
        press(1, 0);
        for (int i = 0; i < 2500; i++) begin
            cycle();
            got = {HEX2, HEX1, HEX0, LEDR0};
            checks++;
            if (got !== exp_out()) begin
                errors++; $display("FAIL pre_pause @%0d: got %h want %h", i, got, exp_out());
            end
        end
        press(1, 0);
        for (int i = 0; i < 5000; i++) begin
            cycle();
            got = {HEX2, HEX1, HEX0, LEDR0};
            checks++;
            if (got !== exp_out()) begin
                errors++; $display("FAIL paused @%0d: got %h want %h", i, got, exp_out());
            end
        end
        checks++;
        if ({HEX2, HEX1, HEX0} !== {7'b1111001, 7'b1111001, 7'b0000000}) begin
            errors++; $display("FAIL pause_11_8: got %h", {HEX2, HEX1, HEX0});
        end
        press(1, 0);
        for (int i = 0; i < 1500; i++) begin
            cycle();
            got = {HEX2, HEX1, HEX0, LEDR0};
            checks++;
            if (got !== exp_out()) begin
                errors++; $display("FAIL resumed @%0d: got %h want %h", i, got, exp_out());
            end
        end
        press(0, 1);
    endtask

    task automatic test_tick_and_start();
        logic [21:0] got;
        SW = 8'h23;
        press(0, 1);
        press(1, 0);
        repeat (992) cycle();
        press(1, 0);  // pulse lands on the tick edge
        for (int i = 0; i < 2000; i++) begin
            cycle();
            got = {HEX2, HEX1, HEX0, LEDR0};
            checks++;
            if (got !== exp_out()) begin
                errors++; $display("FAIL tick_and_start @%0d: got %h want %h", i, got, exp_out());
            end
        end
        press(0, 1);
    endtask

    task automatic test_simultaneous();
        logic [21:0] got;
        SW = 8'h34;
        press(0, 1);
        press(1, 0);
        repeat (1200) cycle();
        SW = 8'($urandom);
        press(1, 1);
        for (int i = 0; i < 3000; i++) begin
            cycle();
            got = {HEX2, HEX1, HEX0, LEDR0};
            checks++;
            if (got !== exp_out()) begin
                errors++; $display("FAIL load_wins @%0d: got %h want %h", i, got, exp_out());
            end
        end
    endtask

    task automatic test_random();
        logic [21:0] got;
        int n;
        for (int it = 0; it < 4; it++) begin
            SW = 8'($urandom);
            press(0, 1);
            press(1, 0);
            for (int seg = 0; seg < 3; seg++) begin
                n = int'($urandom_range(2000, 200));
                for (int i = 0; i < n; i++) begin
                    cycle();
                    got = {HEX2, HEX1, HEX0, LEDR0};
                    checks++;
                    if (got !== exp_out()) begin
                        errors++; $display("FAIL random it%0d seg%0d: got %h want %h", it, seg, got, exp_out());
                    end
                end
                if (seg < 2) press(1, 0);
            end
        end
        press(0, 1);
    endtask

    task automatic test_reset_midrun();
        logic [21:0] got;
        SW = 8'h55;
        press(0, 1);
        press(1, 0);
        repeat (1500) cycle();
        KEY0 = 1'b0;
        model_reset();
        #1;
        got = {HEX2, HEX1, HEX0, LEDR0};
        checks++;
        if (got !== exp_out()) begin
            errors++; $display("FAIL reset_async: got %h want %h", got, exp_out());
        end
        @(posedge clk); #1;
        KEY0 = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            cycle();
            got = {HEX2, HEX1, HEX0, LEDR0};
            checks++;
            if (got !== exp_out()) begin
                errors++; $display("FAIL after_reset @%0d: got %h want %h", i, got, exp_out());
            end
        end
    endtask

`ifdef ALARM_BLINK_EN
    task automatic test_blink();
        logic [21:0] got;
        SW = 8'h01;
        press(0, 1);
        press(1, 0);
        for (int i = 0; i < 21000; i++) begin
            cycle();
            got = {HEX2, HEX1, HEX0, LEDR0};
            checks++;
            if (got !== exp_out()) begin
                errors++; $display("FAIL blink @%0d: got %h want %h", i, got, exp_out());
            end
        end
        press(0, 1);
    endtask
`endif

    initial begin
        ev_start = 0;
        ev_load  = 0;
        test_reset();
        test_load();
        test_countdown_done();
        test_one_tick();
        test_pause_resume();
        test_tick_and_start();
        test_simultaneous();
        test_random();
        test_reset_midrun();
`ifdef ALARM_BLINK_EN
        test_blink();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Board-level countdown timer, the counterpart of the stopwatch: it counts a preset time down to zero rather than up from zero. The preset is loaded from slide switches in whole seconds (00–99). The block counts down in 0.1 s ticks on three active-low 7-segment digits and raises an alarm LED at zero. It sits directly on the DE-board pins: KEY buttons, SW switches, HEX displays and LEDR.

## Interface
- MIN_COUNT_IN_MS, 100, tick period in ms (one tenths-digit step)
- FREQ_MHZ, 50, clk frequency; tick divider DIV = FREQ_MHZ*1000*MIN_COUNT_IN_MS cycles
- clk  in  1  system clock
- KEY0  in  1  reset; one clock; reset is asynchronous and active-low
- KEY1  in  1  start/pause button, active-low, asynchronous to clk
- KEY2  in  1  load button, active-low, asynchronous to clk
- SW  in  8  preset: SW[7:4] tens of seconds, SW[3:0] units of seconds (BCD)
- HEX0  out  7  tenths digit, active-low segments {g,f,e,d,c,b,a}
- HEX1  out  7  seconds units digit
- HEX2  out  7  seconds tens digit
- LEDR0  out  1  alarm, high in DONE

## Operation
- Buttons: each KEY1/KEY2 goes through a 2-flop synchronizer, then a press (1→0) edge detector. The detector output is a registered 1-cycle pulse (start_p, load_p). SW is sampled on load_p only and needs no synchronizer.
- Count: three BCD digits {tens, units, tenths}. Load value = {min(SW[7:4],9), min(SW[3:0],9), 0}; nibbles A–F saturate to 9.
- Prescaler: ceil(log2(DIV))-bit counter. Increments only in RUN and holds its value in PAUSE. Cleared by reset, by load_p, and on entering RUN from IDLE. At value DIV-1 it wraps to 0 and emits tick.
- Decrement on tick: tenths-1. On borrow (tenths==0) tenths=9 and units-1. On borrow (units==0) units=9 and tens-1. The count never goes below 000.
- FSM states IDLE, RUN, PAUSE, DONE; all transitions on clk:
  - IDLE: load_p → load, stay IDLE. start_p with count≠000 → RUN. start_p with count==000 → ignored.
  - RUN: tick → decrement. If the result is 000 → DONE. start_p → PAUSE. load_p → load, go to IDLE.
  - PAUSE: start_p → RUN with prescaler preserved. load_p → load, go to IDLE.
  - DONE: LEDR0=1. start_p → IDLE with count 000. load_p → load, go to IDLE.
- Simultaneous events:
  - load_p and start_p in the same cycle: load wins → IDLE.
  - tick and start_p in the same RUN cycle: decrement applies first. If the result is 000 → DONE; otherwise → PAUSE.
- Display encoding: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.

## Timing
- Reset (KEY0 low, any time including mid-run):
  - Takes effect immediately: state IDLE, count 000, prescaler 0, pulses 0, synchronizer flops 1 (released).
  - Outputs: HEX0/1/2=1000000, LEDR0=0.
  - Buttons held pressed through reset release produce no pulse.
- Button latency: from a KEY falling edge, the pulse is high on the 3rd rising clk edge. The count/state update at the 4th edge. HEX/LEDR are registered and update at the 5th edge.
- One pulse per press. Holding the key generates no further pulses. Bouncing is not filtered; each clean edge counts.
- RUN from IDLE: first tick DIV cycles after the RUN state is entered, then every DIV cycles. HEX follows the count 1 cycle after each tick.
- Pause/resume: total cycles in RUN between ticks is always DIV, regardless of pauses.
- DONE entry: LEDR0 rises 1 cycle after the final tick, together with HEX showing 000.

## Configuration
- ALARM_BLINK_EN defined: in DONE all three HEX digits alternate between 1000000 and blank (1111111). The phase toggles every 5 ticks, with the prescaler free-running in DONE. The first phase is 000 shown. LEDR0 stays steady high.
- Undefined: in DONE the HEX digits show steady 000 and the prescaler is idle.

## Test plan
Benches use FREQ_MHZ=1, MIN_COUNT_IN_MS=1 (DIV=1000).
- Reset release with no presses → HEX0/1/2=1000000, LEDR0=0. Assert KEY0 mid-RUN → same values on the next sampled cycle, state IDLE.
- SW=8'h12, press KEY2 → 5 edges later HEX2=1111001, HEX1=0100100, HEX0=1000000. SW=8'hFA then load → display 99.0 (HEX2=HEX1=0010000).
- Load 01, press KEY1 → after 10×1000 RUN cycles LEDR0=1 and HEX=000. Further start press → LEDR0=0, IDLE. Load 10, run one tick → display 09.9.
- Load 12, start, press KEY1 after 2500 cycles → display 11.8 held for 5000 cycles. Resume → 11.7 exactly 500 RUN cycles later.
- KEY1 and KEY2 falling in the same cycle while in RUN → load wins, state IDLE, count = SW value, no further ticks. Start press with count 000 in IDLE → nothing changes.
- ALARM_BLINK_EN defined, reach DONE → HEX toggles 000/blank every 5000 cycles while LEDR0 stays 1.
